// File: rtl/hack_cpu_core_pkg.sv
// Shared Hack instruction field positions and the decoded-instruction view
// used by the core.
package hack_cpu_core_pkg;

    localparam int unsigned C_FLAG   = 15;
    localparam int unsigned A_SEL    = 12;
    localparam int unsigned COMP_MSB = 11;
    localparam int unsigned COMP_LSB = 6;
    localparam int unsigned DEST_A   = 5;
    localparam int unsigned DEST_D   = 4;
    localparam int unsigned DEST_M   = 3;
    localparam int unsigned JLT      = 2;
    localparam int unsigned JEQ      = 1;
    localparam int unsigned JGT      = 0;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 15;

    typedef enum logic {
        INSTR_A = 1'b0,
        INSTR_C = 1'b1
    } instr_kind_e;

    // comp holds zx,nx,zy,ny,f,no from MSB to LSB.
    typedef struct packed {
        instr_kind_e kind;
        logic        a_sel;
        logic [5:0]  comp;
        logic        dest_a;
        logic        dest_d;
        logic        dest_m;
        logic        jlt;
        logic        jeq;
        logic        jgt;
    } decode_t;

endpackage

// File: rtl/hack_cpu_core_alu.sv
// Hack ALU: conditional zero/negate of each operand, add or AND, optional
// output negate, plus zero and negative flags.
module hack_cpu_core_alu (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic        zx_i,
    input  logic        nx_i,
    input  logic        zy_i,
    input  logic        ny_i,
    input  logic        f_i,
    input  logic        no_i,
    output logic [15:0] out_o,
    output logic        zr_o,
    output logic        ng_o
);

    logic [15:0] x_z, x_n, y_z, y_n, res;

    always_comb begin
        x_z = zx_i ? 16'h0000 : x_i;
        x_n = nx_i ? ~x_z : x_z;
        y_z = zy_i ? 16'h0000 : y_i;
        y_n = ny_i ? ~y_z : y_z;
        // Carry out of bit 15 is dropped: plain 16-bit two's complement.
        res = f_i ? (x_n + y_n) : (x_n & y_n);
        out_o = no_i ? ~res : res;
    end

    assign zr_o = (out_o == 16'h0000);
    assign ng_o = out_o[15];

endmodule

// File: rtl/hack_cpu_core.sv
// Single-cycle Hack CPU core: A/D/PC registers, instruction decode, ALU
// operand selection, writeback, RAM write strobe and conditional jump.
module hack_cpu_core
    import hack_cpu_core_pkg::*;
#(
    parameter logic [14:0] RESET_PC = 15'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        instr_valid,
    input  logic [15:0] inM,
    output logic [15:0] outM,
    output logic        writeM,
    output logic [14:0] addressM,
    output logic [14:0] pc,
    output logic [15:0] a_dbg,
    output logic [15:0] d_dbg
);

    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [14:0] pc_q, pc_d;

    decode_t     dec;
    logic [15:0] alu_y;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        jump;

    always_comb begin
        dec        = '0;
        dec.kind   = instr_kind_e'(instruction[C_FLAG]);
        dec.a_sel  = instruction[A_SEL];
        dec.comp   = instruction[COMP_MSB:COMP_LSB];
        dec.dest_a = instruction[DEST_A];
        dec.dest_d = instruction[DEST_D];
        dec.dest_m = instruction[DEST_M];
        dec.jlt    = instruction[JLT];
        dec.jeq    = instruction[JEQ];
        dec.jgt    = instruction[JGT];
    end

    assign alu_y = dec.a_sel ? inM : a_q;

    hack_cpu_core_alu u_alu (
        .x_i   (d_q),
        .y_i   (alu_y),
        .zx_i  (dec.comp[5]),
        .nx_i  (dec.comp[4]),
        .zy_i  (dec.comp[3]),
        .ny_i  (dec.comp[2]),
        .f_i   (dec.comp[1]),
        .no_i  (dec.comp[0]),
        .out_o (alu_out),
        .zr_o  (alu_zr),
        .ng_o  (alu_ng)
    );

    assign jump = (dec.kind == INSTR_C) &
                  ((dec.jlt & alu_ng) |
                   (dec.jeq & alu_zr) |
                   (dec.jgt & ~alu_ng & ~alu_zr));

    // Jump target uses a_q, i.e. A before this instruction's own writeback.
    always_comb begin
        a_d  = a_q;
        d_d  = d_q;
        pc_d = pc_q;
        if (instr_valid) begin
            if (dec.kind == INSTR_A) begin
                a_d = instruction;
            end else begin
                if (dec.dest_a) a_d = alu_out;
                if (dec.dest_d) d_d = alu_out;
            end
            pc_d = jump ? a_q[14:0] : (pc_q + 15'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= 16'h0000;
            d_q  <= 16'h0000;
            pc_q <= RESET_PC;
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

    assign outM     = alu_out;
    assign writeM   = instr_valid & (dec.kind == INSTR_C) & dec.dest_m & ~reset;
    assign addressM = a_q[14:0];
    assign pc       = pc_q;
    assign a_dbg    = a_q;
    assign d_dbg    = d_q;

endmodule

// File: tb/tb_hack_cpu_core.sv
// Bench for hack_cpu_core: directed program fragments followed by random
// instruction streams, checked against a mnemonic-level Hack model.
module tb_hack_cpu_core;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [15:0] inM;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;
    logic [15:0] a_dbg;
    logic [15:0] d_dbg;

    hack_cpu_core #(.RESET_PC(15'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .inM         (inM),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .pc          (pc),
        .a_dbg       (a_dbg),
        .d_dbg       (d_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [46:0] exp_q[$];
    logic [15:0] m_a;
    logic [15:0] m_d;
    logic [14:0] m_pc;

    // The 18 standard Hack computations (zx nx zy ny f no).
    logic [5:0] comp_tab [0:17] = '{6'h2A, 6'h3F, 6'h3A, 6'h0C, 6'h30, 6'h0D,
                                    6'h31, 6'h0F, 6'h33, 6'h1F, 6'h37, 6'h0E,
                                    6'h32, 6'h02, 6'h13, 6'h07, 6'h00, 6'h15};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference ALU by mnemonic: d is D, y is A or M.
    task automatic ref_alu(input logic [5:0] comp, input logic [15:0] d, input logic [15:0] y,
                           output logic [15:0] r, output logic known);
        known = 1'b1;
        r = 16'h0000;
        case (comp)
            6'h2A: r = 16'h0000;
            6'h3F: r = 16'h0001;
            6'h3A: r = 16'hFFFF;
            6'h0C: r = d;
            6'h30: r = y;
            6'h0D: r = ~d;
            6'h31: r = ~y;
            6'h0F: r = -d;
            6'h33: r = -y;
            6'h1F: r = d + 16'd1;
            6'h37: r = y + 16'd1;
            6'h0E: r = d - 16'd1;
            6'h32: r = y - 16'd1;
            6'h02: r = d + y;
            6'h13: r = d - y;
            6'h07: r = y - d;
            6'h00: r = d & y;
            6'h15: r = d | y;
            default: known = 1'b0;
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [15:0] instr, input logic valid, input logic [15:0] inm);
        logic [15:0] y;
        logic [15:0] res;
        logic        known;
        logic        take;
        logic [14:0] npc;
        logic [46:0] e;
        @(negedge clk);
        instruction = instr;
        instr_valid = valid;
        inM         = inm;
        y = instr[12] ? inm : m_a;
        ref_alu(instr[11:6], m_d, y, res, known);
        #1;
        if (instr[15] && known) check("outM", {16'h0, outM}, {16'h0, res});
        check("writeM", {31'h0, writeM}, {31'h0, valid & instr[15] & instr[3]});
        check("addressM", {17'h0, addressM}, {17'h0, m_a[14:0]});
        if (valid) begin
            npc = m_pc + 15'd1;
            if (instr[15]) begin
                take = (instr[2] && $signed(res) < 0) ||
                       (instr[1] && res == 16'h0000) ||
                       (instr[0] && $signed(res) > 0);
                if (take) npc = m_a[14:0];
                if (instr[5]) m_a = res;
                if (instr[4]) m_d = res;
            end else begin
                m_a = instr;
            end
            m_pc = npc;
        end
        exp_q.push_back({m_a, m_d, m_pc});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("A", {16'h0, a_dbg}, {16'h0, e[46:31]});
        check("D", {16'h0, d_dbg}, {16'h0, e[30:15]});
        check("pc", {17'h0, pc}, {17'h0, e[14:0]});
    endtask

    task automatic exec(input logic [15:0] instr);
        step(instr, 1'b1, 16'h0000);
    endtask

    // Reset pulsed between edges while a valid M-write is presented.
    task automatic pulse_reset();
        instruction = 16'hE308;
        instr_valid = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("rst_A", {16'h0, a_dbg}, 32'h0);
        check("rst_D", {16'h0, d_dbg}, 32'h0);
        check("rst_pc", {17'h0, pc}, 32'h0);
        check("rst_writeM", {31'h0, writeM}, 32'h0);
        #1 reset = 1'b0;
        instr_valid = 1'b0;
        m_a = 16'h0;
        m_d = 16'h0;
        m_pc = 15'd0;
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [14:0] pc_before;
        logic [15:0] instr;
        m_a = 16'h0;
        m_d = 16'h0;
        m_pc = 15'd0;
        reset = 1'b1;
        instr_valid = 1'b0;
        instruction = 16'hE308;
        inM = 16'h0;
        #2;
        check("por_A", {16'h0, a_dbg}, 32'h0);
        check("por_D", {16'h0, d_dbg}, 32'h0);
        check("por_pc", {17'h0, pc}, 32'h0);
        check("por_writeM", {31'h0, writeM}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // D=A, D=D+A
        exec(16'h0005); exec(16'hEC10); exec(16'h0007); exec(16'hE090);
        check("seq_D", {16'h0, d_dbg}, 32'd12);
        check("seq_A", {16'h0, a_dbg}, 32'd7);
        check("seq_pc", {17'h0, pc}, 32'd4);

        // M=D at @100
        exec(16'h0064);
        @(negedge clk);
        instruction = 16'hE308; instr_valid = 1'b1; inM = 16'h0;
        #1;
        check("mw_writeM", {31'h0, writeM}, 32'd1);
        check("mw_addr", {17'h0, addressM}, 32'd100);
        check("mw_outM", {16'h0, outM}, 32'd12);
        @(posedge clk);
        #1;
        m_pc = m_pc + 15'd1;
        check("mw_pc", {17'h0, pc}, 32'd6);

        // D;JGT with D=12, D=0; D;JLT with D=-1
        exec(16'h000A); exec(16'hE301);
        check("jgt_taken", {17'h0, pc}, 32'd10);
        exec(16'hEA90); exec(16'h000A);
        pc_before = pc;
        exec(16'hE301);
        check("jgt_zero", {17'h0, pc}, {17'h0, pc_before + 15'd1});
        exec(16'hEE90); exec(16'h000A); exec(16'hE304);
        check("jlt_taken", {17'h0, pc}, 32'd10);

        // A=D;JMP jumps to the old A
        exec(16'h0009); exec(16'hEC10); exec(16'h0003); exec(16'hE327);
        check("jmp_pc", {17'h0, pc}, 32'd3);
        check("jmp_A", {16'h0, a_dbg}, 32'd9);
        step(16'hFC10, 1'b1, 16'hFFFF);
        check("dm_D", {16'h0, d_dbg}, 32'hFFFF);

        // stall with M=D presented
        repeat (3) step(16'hE308, 1'b0, 16'h1234);

        // PC wrap
        exec(16'h7FFF); exec(16'hEA87);
        check("wrap_pre", {17'h0, pc}, 32'h7FFF);
        exec(16'h0001);
        check("wrap_pc", {17'h0, pc}, 32'h0);

        // mid-run reset after @5
        exec(16'h0005);
        check("pre_rst_A", {16'h0, a_dbg}, 32'd5);
        pulse_reset();

        // random streams
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                instr = {1'b0, 15'($urandom_range(0, 32'h7FFF))};
            end else begin
                instr = {1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         comp_tab[$urandom_range(0, 17)],
                         3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            end
            step(instr, ($urandom_range(0, 99) < 85), 16'($urandom_range(0, 16'hFFFF)));
            if (i == 200) begin
                #1;
                pulse_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
